// File: rtl/coord_merger.sv
// Radix-N merge element: registered argmin over sorted lane heads,
// with a one-hot pop request toward the winning lane.
module coord_merger #(
    parameter int MERGER_RADIX      = 4,
    parameter int MERGER_COORD_BITS = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] coord_in,
    output logic [MERGER_COORD_BITS-1:0]          coord,
    input  logic                                  selected,
    output logic [MERGER_RADIX-1:0]               fetch_next
);

    localparam int R   = MERGER_RADIX;
    localparam int W   = MERGER_COORD_BITS;
    localparam int LVL = $clog2(R);
    localparam int P   = 1 << LVL;
    localparam int IW  = LVL;

    logic [W-1:0]  coord_d, coord_q;
    logic [R-1:0]  fetch_d, fetch_q;
    logic [W-1:0]  min_val;
    logic [IW-1:0] min_idx;
    logic          all_sent;

    // Level LVL holds the (padded) leaves, level 0 is the root.
    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        logic [W-1:0]  v  [1<<k];
        logic [IW-1:0] ix [1<<k];
        for (genvar n = 0; n < (1 << k); n++) begin : g_node
            if (k == LVL) begin : g_leaf
                if (n < R) begin : g_real
                    assign v[n] = coord_in[n*W +: W];
                end else begin : g_pad
                    assign v[n] = '1;
                end
                assign ix[n] = IW'(n);
            end else begin : g_cmp
                // Right operand wins only when strictly smaller.
                logic take_r;
                assign take_r = g_lvl[k+1].v[2*n+1] < g_lvl[k+1].v[2*n];
                assign v[n]  = take_r ? g_lvl[k+1].v[2*n+1]
                                      : g_lvl[k+1].v[2*n];
                assign ix[n] = take_r ? g_lvl[k+1].ix[2*n+1]
                                      : g_lvl[k+1].ix[2*n];
            end
        end
    end

    assign min_val  = g_lvl[0].v[0];
    assign min_idx  = g_lvl[0].ix[0];
    assign all_sent = (min_val == '1);

    always_comb begin
        coord_d = min_val;
        fetch_d = '0;
        if (selected && !all_sent) begin
            for (int i = 0; i < R; i++) begin
                if (min_idx == IW'(i)) fetch_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coord_q <= '0;
            fetch_q <= '0;
        end else begin
            coord_q <= coord_d;
            fetch_q <= fetch_d;
        end
    end

    assign coord      = coord_q;
    assign fetch_next = fetch_q;

endmodule

// File: tb/tb_coord_merger.sv
// Directed and merge-model bench for coord_merger (radix 4/8-bit,
// radix 3/16-bit and radix 8/16-bit instances).
module tb_coord_merger;

    logic clock;
    logic reset;

    logic [31:0] ci4;
    logic [7:0]  co4;
    logic        sel4;
    logic [3:0]  fn4;

    logic [47:0]  ci3;
    logic [15:0]  co3;
    logic         sel3;
    logic [2:0]   fn3;

    logic [127:0] ci8;
    logic [15:0]  co8;
    logic         sel8;
    logic [7:0]   fn8;

    int errs;
    int checks;

    coord_merger #(.MERGER_RADIX(4), .MERGER_COORD_BITS(8)) u_dut4 (
        .clock(clock), .reset(reset), .coord_in(ci4), .coord(co4),
        .selected(sel4), .fetch_next(fn4));

    coord_merger #(.MERGER_RADIX(3), .MERGER_COORD_BITS(16)) u_dut3 (
        .clock(clock), .reset(reset), .coord_in(ci3), .coord(co3),
        .selected(sel3), .fetch_next(fn3));

    coord_merger #(.MERGER_RADIX(8), .MERGER_COORD_BITS(16)) u_dut8 (
        .clock(clock), .reset(reset), .coord_in(ci8), .coord(co8),
        .selected(sel8), .fetch_next(fn8));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step4(input string tag,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3,
                         input logic s, input logic [7:0] ec,
                         input logic [3:0] ef);
        ci4  = {a3, a2, a1, a0};
        sel4 = s;
        @(posedge clock);
        #1;
        chk({tag, "_coord"}, 32'(co4), 32'(ec));
        chk({tag, "_fetch"}, 32'(fn4), 32'(ef));
    endtask

    task automatic run_merge(input int r);
        logic [15:0] s [8][6];
        logic [15:0] heads [8];
        int          ptr [8];
        int          pops;
        int          w;
        int          v;
        logic [15:0] m;
        logic [15:0] last;
        logic [15:0] co;
        logic [7:0]  fn;
        logic [7:0]  efn;
        for (int l = 0; l < 8; l++) begin
            v = int'($urandom_range(0, 50));
            for (int k = 0; k < 6; k++) begin
                s[l][k] = 16'(v);
                v += int'($urandom_range(0, 40));
            end
            ptr[l] = 0;
        end
        pops = 0;
        last = '0;
        for (int cyc = 0; cyc < r * 6 + 3; cyc++) begin
            m = 16'hFFFF;
            w = -1;
            for (int l = 0; l < 8; l++) begin
                heads[l] = (l < r && ptr[l] < 6) ? s[l][ptr[l]] : 16'hFFFF;
                if (l < r && heads[l] < m) begin
                    m = heads[l];
                    w = l;
                end
            end
            for (int l = 0; l < 3; l++) ci3[l*16 +: 16] = heads[l];
            for (int l = 0; l < 8; l++) ci8[l*16 +: 16] = heads[l];
            sel3 = (r == 3);
            sel8 = (r == 8);
            @(posedge clock);
            #1;
            co  = (r == 3) ? co3 : co8;
            fn  = (r == 3) ? {5'b0, fn3} : fn8;
            efn = (w >= 0) ? 8'(1 << w) : 8'h00;
            chk("mrg_coord", 32'(co), 32'(m));
            chk("mrg_fetch", 32'(fn), 32'(efn));
            chk("mrg_order", 32'(co >= last), 32'd1);
            last = co;
            for (int l = 0; l < 8; l++) begin
                if (fn[l]) begin
                    ptr[l]++;
                    pops++;
                end
            end
        end
        sel3 = 1'b0;
        sel8 = 1'b0;
        chk("mrg_pops", 32'(pops), 32'(r * 6));
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        reset  = 1'b0;
        ci4    = {8'd5, 8'd4, 8'd2, 8'd3};
        sel4   = 1'b1;
        ci3    = '1;
        sel3   = 1'b0;
        ci8    = '1;
        sel8   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_coord", 32'(co4), 32'd0);
        chk("rst_fetch", 32'(fn4), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        step4("basic",  8'd3, 8'd2, 8'd4, 8'd5, 1'b1, 8'd2, 4'b0010);
        step4("desel",  8'd3, 8'd2, 8'd4, 8'd5, 1'b0, 8'd2, 4'b0000);
        step4("win0",   8'd2, 8'd3, 8'd4, 8'd5, 1'b1, 8'd2, 4'b0001);
        step4("win0d",  8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 8'd2, 4'b0000);
        step4("win2",   8'd4, 8'd3, 8'd2, 8'd5, 1'b1, 8'd2, 4'b0100);
        step4("win2d",  8'd4, 8'd3, 8'd2, 8'd5, 1'b0, 8'd2, 4'b0000);
        step4("win3",   8'd4, 8'd3, 8'd5, 8'd2, 1'b1, 8'd2, 4'b1000);
        step4("hold",   8'd4, 8'd3, 8'd5, 8'd2, 1'b1, 8'd2, 4'b1000);
        step4("win3d",  8'd4, 8'd3, 8'd5, 8'd2, 1'b0, 8'd2, 4'b0000);
        step4("tie",    8'd7, 8'd3, 8'd3, 8'd9, 1'b1, 8'd3, 4'b0010);
        step4("tieall", 8'd5, 8'd5, 8'd5, 8'd5, 1'b1, 8'd5, 4'b0001);
        step4("zero",   8'd9, 8'd0, 8'd0, 8'd1, 1'b1, 8'd0, 4'b0010);
        step4("sent",   8'hFF, 8'hFF, 8'd6, 8'hFF, 1'b1, 8'd6, 4'b0100);
        step4("allff",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFF, 4'b0000);
        step4("pre_rst", 8'd3, 8'd2, 8'd4, 8'd5, 1'b1, 8'd2, 4'b0010);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_coord", 32'(co4), 32'd0);
        chk("mid_rst_fetch", 32'(fn4), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step4("post_rst", 8'd9, 8'd8, 8'd1, 8'd5, 1'b1, 8'd1, 4'b0100);
        sel4 = 1'b0;

        run_merge(3);
        run_merge(8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
